inv_sub_bytes_seq: RTL and testbench

Iterative InvSubBytes engine for the AES decryption datapath. It accepts a 128-bit state over a valid/ready handshake and runs every byte through `LANES` shared InvSBOX lookups, processing one byte group per cycle. It returns the substituted state over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the decrypt round loop and trades latency for S-box area.

---
 rtl/inv_aes_pkg.sv | 22 ++
 rtl/InvSBOX.sv | 32 +++
 rtl/inv_sub_bytes_seq.sv | 112 +++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_aes_pkg.sv
// Shared definitions for the AES decrypt datapath blocks.
//   STATE_W     : width of one AES state (128 bits)
//   NBYTES      : bytes per state (16)
//   inv_fsm_e   : control states of the iterative InvSubBytes engine
//   lanes_legal : true when a lane count divides the state into whole groups
package inv_aes_pkg;

    localparam int STATE_W = 128;
    localparam int NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } inv_fsm_e;

    function automatic bit lanes_legal(int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/InvSBOX.sv
// Inverse AES S-box, purely combinational byte lookup.
//   in_byte  : byte to substitute
//   out_byte : InvSBOX(in_byte)
// The table is stored with entry k at bits [8k:8k+7], so the first hex pair
// of the first row is entry 0x00.
module InvSBOX (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:2047] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX_TABLE[{in_byte, 3'b000} +: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes engine: substitutes a 128-bit state LANES bytes per
// cycle through shared InvSBOX instances.
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake, in_state captured on valid&&ready
//   in_state  [0:127]    : byte i at bits [8i:8i+7]
//   out_valid/out_ready  : output handshake, result held until accepted
//   out_state [0:127]    : substituted state, same byte order
//   busy                 : control FSM is not in IDLE
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid and data stay stable until that edge, and no ready
// depends combinationally on the opposite side's valid.
module inv_sub_bytes_seq
    import inv_aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:STATE_W-1] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:STATE_W-1] out_state,
    output logic             busy
);

    localparam int N  = NBYTES / LANES;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    if (!lanes_legal(LANES)) begin : g_lanes_check
        $error("inv_sub_bytes_seq: LANES=%0d is not one of 1, 2, 4, 8, 16", LANES);
    end

    inv_fsm_e           st_q, st_d;
    logic [GW-1:0]      grp_q, grp_d;
    logic [0:STATE_W-1] state_q, state_d;

    logic [7:0] sbox_in  [LANES];
    logic [7:0] sbox_out [LANES];

    // Lane j always looks at byte grp*LANES+j; the result is only written
    // back while in RUN.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            sbox_in[j] = state_q[(int'(grp_q) * LANES + j) * 8 +: 8];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        InvSBOX u_inv_sbox (
            .in_byte  (sbox_in[j]),
            .out_byte (sbox_out[j])
        );
    end

    always_comb begin
        st_d    = st_q;
        grp_d   = grp_q;
        state_d = state_q;
        case (st_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_state;
                    grp_d   = '0;
                    st_d    = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < LANES; j++) begin
                    state_d[(int'(grp_q) * LANES + j) * 8 +: 8] = sbox_out[j];
                end
                // Wrap to 0 on the last group so grp never addresses past
                // the state (matters when N is 1).
                if (grp_q == GW'(N - 1)) begin
                    grp_d = '0;
                    st_d  = DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            grp_q   <= '0;
            state_q <= '0;
        end else begin
            st_q    <= st_d;
            grp_q   <= grp_d;
            state_q <= state_d;
        end
    end

    // in_ready is masked by rst so nothing is accepted while reset is held.
    assign in_ready  = (st_q == IDLE) && !rst;
    assign out_valid = (st_q == DONE);
    assign busy      = (st_q != IDLE);
    assign out_state = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq. Five instances cover LANES = 4, 1,
// 2, 8, 16; instance 0 (LANES=4) carries the handshake and reset scenarios.
module tb_inv_sub_bytes_seq;

    localparam int NDUT = 5;
    localparam int LANES_TAB [NDUT] = '{4, 1, 2, 8, 16};
    // Edges from acceptance (acceptance edge counted as 1) to out_valid.
    localparam int LAT_TAB [NDUT] = '{5, 17, 9, 3, 2};

    localparam logic [0:127] ALL00   = 128'h00000000000000000000000000000000;
    localparam logic [0:127] ALL52   = 128'h52525252525252525252525252525252;
    localparam logic [0:127] ALL63   = 128'h63636363636363636363636363636363;
    localparam logic [0:127] ALLFF   = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [0:127] ALL7D   = 128'h7d7d7d7d7d7d7d7d7d7d7d7d7d7d7d7d;
    localparam logic [0:127] SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] SEQ_EXP = 128'h52096ad53036a538bf40a39e81f3d7fb;

    logic         clk;
    logic         rst;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [0:127] in_state  [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [0:127] out_state [NDUT];
    logic         busy      [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        inv_sub_bytes_seq #(.LANES(LANES_TAB[k])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_state  (in_state[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_state (out_state[k]),
            .busy      (busy[k])
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Offers one block to instance k, measures latency, checks the result and,
    // when hs is set, the handshake edge back to IDLE.
    task automatic run_block(input int k, input logic [0:127] data, input logic [0:127] exp,
                             input int lat_exp, input string tag, input bit hs);
        int waits = 0;
        int lat;
        @(negedge clk);
        in_state[k] = data;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check($sformatf("%s_accept_ready", tag), 128'(in_ready[k]), 128'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid[k]) break;
        end
        check($sformatf("%s_latency", tag), 128'(lat), 128'(lat_exp));
        check($sformatf("%s_out_state", tag), out_state[k], exp);
        check($sformatf("%s_busy_done", tag), 128'(busy[k]), 128'd1);
        if (hs) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_valid_after_hs", tag), 128'(out_valid[k]), 128'd0);
            check($sformatf("%s_ready_after_hs", tag), 128'(in_ready[k]), 128'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int outs;
        int acc_cyc [2];
        logic [0:127] got [2];

        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_in_ready_%0d", k), 128'(in_ready[k]), 128'd0);
            check($sformatf("rst_out_valid_%0d", k), 128'(out_valid[k]), 128'd0);
            check($sformatf("rst_busy_%0d", k), 128'(busy[k]), 128'd0);
            check($sformatf("rst_out_state_%0d", k), out_state[k], 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("post_rst_in_ready_%0d", k), 128'(in_ready[k]), 128'd1);
        end

        // Main function on LANES=4
        run_block(0, ALL00, ALL52, LAT_TAB[0], "zeros", 1'b1);
        run_block(0, SEQ, SEQ_EXP, LAT_TAB[0], "seq_l4", 1'b1);
        run_block(0, ALL63, ALL00, LAT_TAB[0], "all63", 1'b1);
        run_block(0, ALLFF, ALL7D, LAT_TAB[0], "allff", 1'b1);

        // Other lane counts
        for (int k = 1; k < NDUT; k++) begin
            run_block(k, SEQ, SEQ_EXP, LAT_TAB[k], $sformatf("seq_l%0d", LANES_TAB[k]), 1'b1);
        end

        // Backpressure: result must hold and a new offer must be ignored
        out_ready[0] = 1'b0;
        run_block(0, SEQ, SEQ_EXP, LAT_TAB[0], "bp", 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                in_state[0] = ALLFF;
                in_valid[0] = 1'b1;
            end else begin
                in_valid[0] = 1'b0;
            end
            check($sformatf("bp_hold_state_%0d", i), out_state[0], SEQ_EXP);
            check($sformatf("bp_hold_valid_%0d", i), 128'(out_valid[0]), 128'd1);
            check($sformatf("bp_hold_in_ready_%0d", i), 128'(in_ready[0]), 128'd0);
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 128'(out_valid[0]), 128'd0);
        check("bp_release_in_ready", 128'(in_ready[0]), 128'd1);
        check("bp_release_busy", 128'(busy[0]), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_pulse_ignored_busy", 128'(busy[0]), 128'd0);
        check("bp_pulse_ignored_state", out_state[0], SEQ_EXP);

        // Asynchronous reset during RUN cycle 2
        @(negedge clk);
        in_state[0] = ALL63;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        #3;
        check("mid_run_busy_before", 128'(busy[0]), 128'd1);
        rst = 1'b1;
        #1;
        check("mid_run_rst_valid", 128'(out_valid[0]), 128'd0);
        check("mid_run_rst_busy", 128'(busy[0]), 128'd0);
        check("mid_run_rst_state", out_state[0], 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("after_rst_idle_valid", 128'(out_valid[0]), 128'd0);
        run_block(0, ALLFF, ALL7D, LAT_TAB[0], "after_rst", 1'b1);

        // Back-to-back with in_valid held high
        acc  = 0;
        outs = 0;
        @(negedge clk);
        in_state[0] = SEQ;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 60 && (acc < 2 || outs < 2); c++) begin
            if (c > 0) @(negedge clk);
            if (acc == 1) in_state[0] = ALL00;
            if (acc == 2) in_valid[0] = 1'b0;
            if (out_valid[0] && outs < 2) begin
                got[outs] = out_state[0];
                outs++;
            end
            if (in_valid[0] && in_ready[0] && acc < 2) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
        end
        in_valid[0] = 1'b0;
        check("b2b_accept_count", 128'(acc), 128'd2);
        check("b2b_output_count", 128'(outs), 128'd2);
        if (acc == 2) begin
            check("b2b_accept_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
        end
        if (outs == 2) begin
            check("b2b_result_0", got[0], SEQ_EXP);
            check("b2b_result_1", got[1], ALL52);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
